// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM arbiter: VGA has priority with a fairness cap; CPU and AUX share round-robin.
// One transaction at a time through IDLE -> ISSUE -> WAIT -> DONE.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VGA_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vga_req,
    input  logic              vga_we,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic              vga_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,

    output logic [DATA_W-1:0] rdata,

    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic              sd_ack,
    input  logic [DATA_W-1:0] sd_rdata,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    localparam logic [1:0] GntNone = 2'd0;
    localparam logic [1:0] GntVga  = 2'd1;
    localparam logic [1:0] GntCpu  = 2'd2;
    localparam logic [1:0] GntAux  = 2'd3;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_vga_cnt;
    logic              r_rr_aux;

    logic              w_other;
    logic              w_vga_sat;
    logic [1:0]        w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_busy;

    assign w_other   = cpu_req | aux_req;
    assign w_vga_sat = (r_vga_cnt >= 4'(VGA_MAX));
    assign w_busy    = (r_state == StIssue) || (r_state == StWait);

    // VGA yields only once it has used its quota and someone else is waiting.
    always_comb begin
        w_win = GntNone;
        if (vga_req && !(w_vga_sat && w_other)) begin
            w_win = GntVga;
        end else if (cpu_req && aux_req) begin
            w_win = r_rr_aux ? GntAux : GntCpu;
        end else if (cpu_req) begin
            w_win = GntCpu;
        end else if (aux_req) begin
            w_win = GntAux;
        end
    end

    always_comb begin
        w_win_we    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        unique case (w_win)
            GntVga: begin
                w_win_we    = vga_we;
                w_win_addr  = vga_addr;
                w_win_wdata = vga_wdata;
            end
            GntCpu: begin
                w_win_we    = cpu_we;
                w_win_addr  = cpu_addr;
                w_win_wdata = cpu_wdata;
            end
            GntAux: begin
                w_win_we    = aux_we;
                w_win_addr  = aux_addr;
                w_win_wdata = aux_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_win != GntNone) w_state_nxt = StIssue;
            StIssue: w_state_nxt = sd_ack ? StDone : StWait;
            StWait:  if (sd_ack) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_grant   <= GntNone;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_vga_cnt <= 4'd0;
            r_rr_aux  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && w_win != GntNone) begin
                r_grant <= w_win;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
                if (w_win == GntVga) begin
                    // Count only streaks that actually starve someone.
                    if (!w_other)       r_vga_cnt <= 4'd0;
                    else if (!w_vga_sat) r_vga_cnt <= r_vga_cnt + 4'd1;
                end else begin
                    r_vga_cnt <= 4'd0;
                    r_rr_aux  <= (w_win == GntCpu);
                end
            end
            if (r_state == StDone) r_grant <= GntNone;
            if (w_busy && sd_ack)  r_rdata <= sd_rdata;
        end
    end

    assign sd_req   = w_busy;
    assign sd_we    = r_we;
    assign sd_addr  = r_addr;
    assign sd_wdata = r_wdata;
    assign rdata    = r_rdata;
    assign grant    = r_grant;

    assign vga_ack = (r_state == StDone) && (r_grant == GntVga);
    assign cpu_ack = (r_state == StDone) && (r_grant == GntCpu);
    assign aux_ack = (r_state == StDone) && (r_grant == GntAux);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single transfers, arbitration sequences,
// ignored acks and reset mid-transaction.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req, vga_we, vga_ack;
    logic [23:0] vga_addr;
    logic [15:0] vga_wdata;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        aux_req, aux_we, aux_ack;
    logic [23:0] aux_addr;
    logic [15:0] aux_wdata;
    logic [15:0] rdata;
    logic        sd_req, sd_we, sd_ack;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata, sd_rdata;
    logic [1:0]  grant;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .VGA_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
        .vga_ack(vga_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack),
        .rdata(rdata),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_ack(sd_ack), .sd_rdata(sd_rdata),
        .grant(grant)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ISSUE, hold sd_ack off for dly cycles, then ack and check DONE and IDLE.
    task automatic serve(input int dly, input logic [1:0] exp_g, input logic [23:0] exp_addr,
                         input logic exp_we, input logic [15:0] exp_wdata,
                         input logic [15:0] rd, input bit drop);
        int n = 0;
        while (!sd_req && n < 10) begin
            tick();
            n++;
        end
        check_eq("issue_seen", 32'(sd_req), 1);
        check_eq("issue_grant", 32'(grant), 32'(exp_g));
        check_eq("issue_addr", 32'(sd_addr), 32'(exp_addr));
        check_eq("issue_we", 32'(sd_we), 32'(exp_we));
        check_eq("issue_wdata", 32'(sd_wdata), 32'(exp_wdata));
        if (drop) begin
            vga_req = 1'b0;
            cpu_req = 1'b0;
            aux_req = 1'b0;
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            check_eq("wait_req", 32'(sd_req), 1);
            check_eq("wait_addr", 32'(sd_addr), 32'(exp_addr));
            check_eq("wait_wdata", 32'(sd_wdata), 32'(exp_wdata));
            check_eq("wait_grant", 32'(grant), 32'(exp_g));
        end
        sd_ack   = 1'b1;
        sd_rdata = rd;
        tick();
        sd_ack   = 1'b0;
        sd_rdata = 16'h0;
        check_eq("done_ack", 32'({aux_ack, cpu_ack, vga_ack}), 32'(3'b001 << (exp_g - 2'd1)));
        check_eq("done_req", 32'(sd_req), 0);
        check_eq("done_rdata", 32'(rdata), 32'(rd));
        check_eq("done_grant", 32'(grant), 32'(exp_g));
        tick();
        check_eq("idle_ack", 32'({aux_ack, cpu_ack, vga_ack}), 0);
        check_eq("idle_grant", 32'(grant), 0);
    endtask

    function automatic logic [23:0] addr_of(input logic [1:0] g);
        return (g == 2'd1) ? 24'h000030 : (g == 2'd2) ? 24'h000010 : 24'h000020;
    endfunction

    initial begin
        logic [1:0] seq4 [4]  = '{2'd2, 2'd3, 2'd2, 2'd3};
        logic [1:0] seq5 [11] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1,
                                  2'd3, 2'd1};
        reset = 1'b1;
        {vga_req, vga_we, cpu_req, cpu_we, aux_req, aux_we, sd_ack} = '0;
        vga_addr = '0; cpu_addr = '0; aux_addr = '0;
        vga_wdata = '0; cpu_wdata = '0; aux_wdata = '0;
        sd_rdata = '0;

        #3;
        check_eq("rst_sd_req", 32'(sd_req), 0);
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_rdata", 32'(rdata), 0);
        check_eq("rst_sd_addr", 32'(sd_addr), 0);
        check_eq("rst_acks", 32'({aux_ack, cpu_ack, vga_ack}), 0);
        tick();
        tick();
        reset = 1'b0;

        // CPU read with three wait cycles, then CPU drops its request after the ack.
        cpu_addr = 24'h000123;
        cpu_req  = 1'b1;
        serve(3, 2'd2, 24'h000123, 1'b0, 16'h0, 16'hBEEF, 1'b0);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("no_regrant_grant", 32'(grant), 0);
            check_eq("no_regrant_req", 32'(sd_req), 0);
            check_eq("hold_rdata", 32'(rdata), 32'h0000BEEF);
        end

        // AUX write; AUX drops request mid-transaction but still gets its ack.
        aux_we    = 1'b1;
        aux_addr  = 24'h00FFFF;
        aux_wdata = 16'h1234;
        aux_req   = 1'b1;
        serve(2, 2'd3, 24'h00FFFF, 1'b1, 16'h1234, 16'h5A5A, 1'b1);
        aux_we = 1'b0;
        aux_wdata = 16'h0;

        // Stray sd_ack in IDLE is ignored.
        sd_ack   = 1'b1;
        sd_rdata = 16'hDEAD;
        tick();
        sd_ack   = 1'b0;
        check_eq("idle_ack_rdata", 32'(rdata), 32'h00005A5A);
        check_eq("idle_ack_grant", 32'(grant), 0);
        check_eq("idle_ack_acks", 32'({aux_ack, cpu_ack, vga_ack}), 0);
        tick();
        check_eq("idle_ack_req", 32'(sd_req), 0);

        // CPU and AUX alternate.
        vga_addr = addr_of(2'd1);
        cpu_addr = addr_of(2'd2);
        aux_addr = addr_of(2'd3);
        cpu_req  = 1'b1;
        aux_req  = 1'b1;
        for (int i = 0; i < 4; i++)
            serve(1, seq4[i], addr_of(seq4[i]), 1'b0, 16'h0, 16'(16'h0100 + i), 1'b0);
        cpu_req = 1'b0;
        aux_req = 1'b0;
        tick();

        // All three held, immediate ack in ISSUE: VGA capped at four in a row.
        vga_req = 1'b1;
        cpu_req = 1'b1;
        aux_req = 1'b1;
        for (int i = 0; i < 11; i++)
            serve(0, seq5[i], addr_of(seq5[i]), 1'b0, 16'h0, 16'(16'h0200 + i), 1'b0);
        vga_req = 1'b0;
        cpu_req = 1'b0;
        aux_req = 1'b0;
        tick();

        // Reset during WAIT of a VGA read.
        vga_addr = 24'h000ABC;
        vga_req  = 1'b1;
        tick();
        tick();
        check_eq("rst_mid_wait_req", 32'(sd_req), 1);
        check_eq("rst_mid_grant_vga", 32'(grant), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_sd_req", 32'(sd_req), 0);
        check_eq("rst_mid_grant", 32'(grant), 0);
        check_eq("rst_mid_rdata", 32'(rdata), 0);
        check_eq("rst_mid_addr", 32'(sd_addr), 0);
        vga_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_mid_no_ack", 32'({aux_ack, cpu_ack, vga_ack}), 0);
            check_eq("rst_mid_idle", 32'(grant), 0);
        end
        cpu_addr = 24'h000055;
        cpu_req  = 1'b1;
        serve(1, 2'd2, 24'h000055, 1'b0, 16'h0, 16'h7777, 1'b0);
        cpu_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
